// File: rtl/audio_mix_pkg.sv
// Shared types and width helpers for the time-multiplexed audio mixer.
package audio_mix_pkg;

  typedef enum logic [1:0] {IDLE, ACC, OUT} mix_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int unity_gain(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // Sum of NCH full-scale products fits without wrapping.
  function automatic int acc_width(input int in_w, input int gain_w, input int nch);
    return in_w + gain_w + clog2(nch + 1);
  endfunction

  localparam int ACC_W_DEF = acc_width(6, 4, 2);

endpackage

// File: rtl/audio_mix_gain_regs.sv
// Per-channel gain register file: resets to unity, indexed write, read-back mux.
module audio_mix_gain_regs
  import audio_mix_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int GAIN_W = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         gain_we,
  input  logic [3:0]                   gain_ad,
  input  logic [GAIN_W-1:0]            gain_d,
  output logic [NCH-1:0][GAIN_W-1:0]   gains,
  output logic [GAIN_W-1:0]            gain_q
);

  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_W));

  // Indices at or above NCH match no lane, so writes there are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) gains[k] <= UNITY;
    end else if (gain_we) begin
      for (int k = 0; k < NCH; k++)
        if (gain_ad == 4'(k)) gains[k] <= gain_d;
    end
  end

  always_comb begin
    gain_q = '0;
    for (int k = 0; k < NCH; k++)
      if (gain_ad == 4'(k)) gain_q = gains[k];
  end

endmodule

// File: rtl/audio_mixer_seq.sv
// NCH-channel sequential audio mixer: one multiply-accumulate per clock.
// AUDIO_MIX_SAT_EN selects a saturating output clip instead of modulo wrap.
module audio_mixer_seq
  import audio_mix_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int IN_W   = 6,
  parameter int GAIN_W = 4,
  parameter int OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NCH*IN_W-1:0]   snd_in,
  input  logic                  sample_stb,
  input  logic                  gain_we,
  input  logic [3:0]            gain_ad,
  input  logic [GAIN_W-1:0]     gain_d,
  output logic [GAIN_W-1:0]     gain_q,
  output logic [OUT_W-1:0]      sout,
  output logic                  sout_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int ACC_W  = acc_width(IN_W, GAIN_W, NCH);
  localparam int PROD_W = IN_W + GAIN_W;
  localparam int CH_W   = (NCH > 1) ? clog2(NCH) : 1;

  mix_state_e                    state;
  logic [NCH-1:0][IN_W-1:0]      snap;
  logic [NCH-1:0][GAIN_W-1:0]    gains;
  logic [ACC_W-1:0]              acc, acc_nxt, res;
  logic [CH_W-1:0]               ch;
  logic [IN_W-1:0]               cur_smp;
  logic [GAIN_W-1:0]             cur_gain;
  logic [PROD_W-1:0]             prod;
  logic [OUT_W-1:0]              sout_nxt;

  audio_mix_gain_regs #(.NCH(NCH), .GAIN_W(GAIN_W)) u_gain_regs (
    .clk     (clk),
    .reset_n (reset_n),
    .gain_we (gain_we),
    .gain_ad (gain_ad),
    .gain_d  (gain_d),
    .gains   (gains),
    .gain_q  (gain_q)
  );

  // Live gain is read each step, so a mid-mix write affects unprocessed channels.
  always_comb begin
    cur_smp  = '0;
    cur_gain = '0;
    for (int k = 0; k < NCH; k++)
      if (ch == CH_W'(k)) begin
        cur_smp  = snap[k];
        cur_gain = gains[k];
      end
  end

  assign prod    = PROD_W'(cur_smp) * PROD_W'(cur_gain);
  assign acc_nxt = acc + ACC_W'(prod);
  assign res     = acc_nxt >> (GAIN_W - 1);

  always_comb begin
`ifdef AUDIO_MIX_SAT_EN
    sout_nxt = ((res >> OUT_W) != '0) ? '1 : OUT_W'(res);
`else
    sout_nxt = OUT_W'(res);
`endif
  end

  // The last add also loads sout, so sout_valid is high throughout OUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      snap       <= '0;
      acc        <= '0;
      ch         <= '0;
      sout       <= '0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sout_valid <= 1'b0;
      if (sample_stb && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_stb) begin
          snap  <= snd_in;
          acc   <= '0;
          ch    <= '0;
          busy  <= 1'b1;
          state <= ACC;
        end
        ACC: begin
          acc <= acc_nxt;
          ch  <= ch + 1'b1;
          if (ch == CH_W'(NCH - 1)) begin
            sout       <= sout_nxt;
            sout_valid <= 1'b1;
            state      <= OUT;
          end
        end
        OUT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/audio_mixer_seq.md
Name: audio_mixer_seq

Overview:
- Parametrised successor to the fixed two-POKEY sum stage.
- Mixes NCH unsigned sound-generator outputs, each with a CPU-writable per-channel gain.
- Time-multiplexed: one channel per clock, into a single accumulator.
- Drives the 8-bit (default) SOUT bus to the audio DAC/filter path; sits between the POKEY instances and the top-level audio output.

Parameters:
NCH, 2, number of input channels (1..16)
IN_W, 6, width of each channel sample
GAIN_W, 4, width of per-channel gain; unity gain = 2^(GAIN_W-1)
OUT_W, 8, width of mixed output

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
snd_in  in  NCH*IN_W  packed channel samples; channel k at [k*IN_W +: IN_W]
sample_stb  in  1  one-clk pulse requesting a new mix
gain_we  in  1  gain register write strobe
gain_ad  in  4  gain register index
gain_d  in  GAIN_W  gain write data
gain_q  out  GAIN_W  read-back of gain[gain_ad] (combinational mux of registers)
sout  out  OUT_W  mixed output sample, held between mixes
sout_valid  out  1  one-clk pulse when sout updates
busy  out  1  high while mix in progress
overrun  out  1  sticky: sample_stb arrived while busy

Behaviour:
- Reset is asynchronous, active-low. Clock is clk; reset is reset_n.
- Reset values:
  - sout=0, sout_valid=0, busy=0, overrun=0.
  - All gains = 2^(GAIN_W-1) (unity), so default mix equals a plain sum of channels.
  - Accumulator=0, snapshot=0.
- Gain writes:
  - gain_we=1 with gain_ad<NCH writes gain[gain_ad]<=gain_d on the clock edge.
  - gain_ad>=NCH: write ignored; gain_q returns 0.
  - Writes are accepted in any state. A gain changed mid-mix takes effect for any channel not yet processed.
- FSM states IDLE, ACC, OUT.
  - IDLE:
    - On sample_stb, latch all of snd_in into a snapshot register.
    - Clear the accumulator, set channel index ch=0, go to ACC. busy=1 from the next cycle.
  - ACC:
    - Each cycle: acc <= acc + snap[ch]*gain[ch]; ch++.
    - After the ch=NCH-1 add, go to OUT. ACC lasts exactly NCH cycles.
  - OUT:
    - res = acc >> (GAIN_W-1), truncated toward zero.
    - sout <= final(res); sout_valid=1 for this one cycle.
    - busy=0 next cycle; return to IDLE.
- Latency: sample_stb at cycle t gives sout_valid at cycle t+NCH+1. busy is high for NCH+1 cycles.
- Widths:
  - Product width is IN_W+GAIN_W.
  - ACC_W = IN_W+GAIN_W+clog2(NCH+1); the accumulator never wraps.
- sample_stb while busy or in OUT:
  - Ignored; the snapshot is untouched and the current mix completes.
  - overrun<=1. It clears only on reset.
- sample_stb on the same cycle as the OUT state: counts as busy, so it is ignored and sets overrun.
- reset_n asserted mid-mix: immediate abort to IDLE with all reset values; no sout_valid.
- snd_in may change freely after the latch cycle; only the snapshot is used.

Optional Feature:
- Macro AUDIO_MIX_SAT_EN.
- Defined: final(res) = res if res < 2^OUT_W, else all-ones (saturating clip).
- Undefined: final(res) = res[OUT_W-1:0] (modulo wrap, the legacy sum behaviour).
- overrun and all timing are identical in both builds.

Decomposition:
- Package audio_mix_pkg holds:
  - State enum (IDLE, ACC, OUT).
  - Function clog2.
  - Function unity_gain(GAIN_W).
  - Localparam formula for ACC_W.
- One natural sub-module: audio_mix_gain_regs, the NCH x GAIN_W register file with reset-to-unity, write decode and read-back mux. The FSM, MAC and output stage stay in the top.

Test Plan:
1. Reset then defaults, NCH=2: snd=(63,63), stb -> after 3 clk, sout_valid=1, sout=126; busy high for exactly 3 cycles.
2. Gains: set gain0=15, gain1=0; snd=(40,50); stb -> sout=(40*15)>>3=75; gain_q for index 0 reads 15, for index 5 reads 0.
3. Saturation, NCH=4, all gains 15, all snd=63: res = 63*15*4>>3 = 472.
   - With AUDIO_MIX_SAT_EN: sout=255.
   - Without it: sout=472 mod 256=216.
4. Overrun: stb, then a second stb 1 clk later -> single sout_valid with the first snapshot's value; overrun=1 and stays 1.
5. Snapshot hold: stb with snd=(10,20), then change snd to (0,0) next cycle -> sout=30.
6. Mid-mix reset: pulse reset_n low during ACC -> outputs 0 immediately, no sout_valid; gains back to 8; a later stb works normally.
